// File: rtl/posit_mult_issue_if.sv
// Operand, multiplier and result channels of the posit_mult issue stage.
// slave = the issue stage itself; master = its surroundings (source, multiplier, sink).
interface posit_mult_issue_if #(
  parameter int N  = 16,
  parameter int TW = 4
);
  logic          op_valid;
  logic          op_ready;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [TW-1:0] op_tag;

  logic [N-1:0]  mul_in1;
  logic [N-1:0]  mul_in2;
  logic          mul_start;
  logic [N-1:0]  mul_out;
  logic          mul_inf;
  logic          mul_zero;
  logic          mul_done;

  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic          res_inf;
  logic          res_zero;
  logic [TW-1:0] res_tag;

  modport slave (
    input  op_valid, op_a, op_b, op_tag,
    output op_ready,
    output mul_in1, mul_in2, mul_start,
    input  mul_out, mul_inf, mul_zero, mul_done,
    output res_valid, res_data, res_inf, res_zero, res_tag,
    input  res_ready
  );

  modport master (
    output op_valid, op_a, op_b, op_tag,
    input  op_ready,
    input  mul_in1, mul_in2, mul_start,
    output mul_out, mul_inf, mul_zero, mul_done,
    input  res_valid, res_data, res_inf, res_zero, res_tag,
    output res_ready
  );
endinterface

// File: rtl/posit_mult_issue.sv
// Issue/collect stage for posit_mult: operand FIFO, one-op-at-a-time issue FSM,
// and a result register held until the downstream sink accepts it.
module posit_mult_issue #(
  parameter int N     = 16,
  parameter int es    = 3,
  parameter int DEPTH = 4,
  parameter int TW    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  posit_mult_issue_if.slave      bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TW + 2 * N;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("posit_mult_issue: DEPTH must be a power of two >= 2");
  end
  if (es < 0 || es > N - 3) begin : g_bad_es
    $error("posit_mult_issue: es does not fit in an N-bit posit");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  in1_q, in1_d;
  logic [N-1:0]  in2_q, in2_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [N-1:0]  res_data_q, res_data_d;
  logic          res_inf_q, res_inf_d;
  logic          res_zero_q, res_zero_d;
  logic [TW-1:0] res_tag_q, res_tag_d;

  logic          op_ready;
  logic          push;
  logic          pop;
  logic          can_pop;
  logic [EW-1:0] head;

  // op_ready is a pure function of occupancy, keeping sink/multiplier timing off it.
  assign op_ready = (count_q != CW'(DEPTH));
  assign push     = bus.op_valid & op_ready & ~flush;
  assign can_pop  = (count_q != '0) & ~flush;
  assign head     = fifo_q[rd_ptr_q];

  // NOTE: the operand storage is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.op_tag, bus.op_b, bus.op_a};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    // NOTE: every signal gets its default first, so no branch can infer a latch.
    state_d    = state_q;
    pop        = 1'b0;
    in1_d      = in1_q;
    in2_d      = in2_q;
    tag_d      = tag_q;
    res_data_d = res_data_q;
    res_inf_d  = res_inf_q;
    res_zero_d = res_zero_q;
    res_tag_d  = res_tag_q;

    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (bus.mul_done) begin
          res_data_d = bus.mul_out;
          res_inf_d  = bus.mul_inf;
          res_zero_d = bus.mul_zero;
          res_tag_d  = tag_q;
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          if (can_pop) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      in1_d = head[N-1:0];
      in2_d = head[2*N-1:N];
      tag_d = head[EW-1:2*N];
    end
  end

  // NOTE: all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      tag_q      <= '0;
      res_data_q <= '0;
      res_inf_q  <= 1'b0;
      res_zero_q <= 1'b0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      tag_q      <= tag_d;
      res_data_q <= res_data_d;
      res_inf_q  <= res_inf_d;
      res_zero_q <= res_zero_d;
      res_tag_q  <= res_tag_d;
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.mul_in1   = in1_q;
  assign bus.mul_in2   = in2_q;
  assign bus.mul_start = (state_q == S_ISSUE);
  assign bus.res_valid = (state_q == S_HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_inf   = res_inf_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_tag   = res_tag_q;
  assign count         = count_q;
endmodule

// File: tb/tb_posit_mult_issue.sv
// Directed bench for posit_mult_issue with a table-driven stub multiplier
// (done = start, or done three cycles after start in slow mode).
module tb_posit_mult_issue;
  localparam int N     = 16;
  localparam int ES    = 3;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  posit_mult_issue_if #(.N(N), .TW(TW)) bus ();

  posit_mult_issue #(.N(N), .es(ES), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  // Stub multiplier: only the products the vectors need, returned as {inf, zero, out}.
  function automatic logic [N+1:0] stub_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] p;
    if (a == 16'h8000 || b == 16'h8000) return {2'b10, 16'h8000};
    if (a == 16'h0000 || b == 16'h0000) return {2'b01, 16'h0000};
    if (a == 16'h4000)                      p = b;
    else if (b == 16'h4000)                 p = a;
    else if (a == 16'hC000)                 p = -b;
    else if (b == 16'hC000)                 p = -a;
    else if (a == 16'h4400 && b == 16'h4400) p = 16'h4800;
    else                                    p = 16'h0001;
    return {2'b00, p};
  endfunction

  bit slow_mode = 1'b0;
  int pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pend <= 0;
    else if (bus.mul_start) pend <= 3;
    else if (pend != 0)     pend <= pend - 1;
  end
  assign {bus.mul_inf, bus.mul_zero, bus.mul_out} = stub_mul(bus.mul_in1, bus.mul_in2);
  assign bus.mul_done = slow_mode ? (pend == 1) : bus.mul_start;

  // Monitors sample on the falling edge, away from the active edge.
  typedef struct {
    logic [N-1:0]  data;
    logic          inf;
    logic          zero;
    logic [TW-1:0] tag;
    int            cyc;
  } res_t;

  int   cyc = 0;
  int   n_start = 0;
  res_t res_q[$];
  int   acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_valid && bus.res_ready) begin
        res_t r;
        r.data = bus.res_data;
        r.inf  = bus.res_inf;
        r.zero = bus.res_zero;
        r.tag  = bus.res_tag;
        r.cyc  = cyc;
        res_q.push_back(r);
      end
      if (bus.op_valid && bus.op_ready && !flush) acc_q.push_back(cyc);
      if (bus.mul_start) n_start <= n_start + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    res_q.delete();
    acc_q.delete();
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TW-1:0] tag);
    bit taken = 1'b0;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_tag   = tag;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = bus.op_ready;
      tick();
    end
    bus.op_valid = 1'b0;
    if (!taken) check("send_accepted", 32'(taken), 32'd1);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 200 && res_q.size() < n; i++) tick();
    check("res_count", 32'(res_q.size()), 32'(n));
  endtask

  logic [N-1:0] t4_b [6] = '{16'h4400, 16'h4800, 16'hC000, 16'h3000, 16'h5000, 16'h4C00};

  initial begin
    int n_acc;
    int s0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_tag    = '0;
    bus.res_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_op_ready", 32'(bus.op_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {27'd0, bus.mul_start, bus.res_valid, bus.res_inf, bus.res_zero, 1'b0}, 32'd0);
    check("rst_mul_in", {bus.mul_in1, bus.mul_in2}, 32'd0);
    check("rst_res", {12'd0, bus.res_tag, bus.res_data}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // 1: 1*1, latency 3 cycles from accept
    bus.res_ready = 1'b1;
    clear_logs();
    send(16'h4000, 16'h4000, 4'd3);
    wait_results(1);
    check("t1_data", 32'(res_q[0].data), 32'h4000);
    check("t1_inf", 32'(res_q[0].inf), 32'd0);
    check("t1_tag", 32'(res_q[0].tag), 32'd3);
    check("t1_latency", 32'(res_q[0].cyc - acc_q[0]), 32'd3);
    repeat (2) tick();

    // 2: back-to-back 2*2 and -1*1, two cycles apart
    clear_logs();
    send(16'h4400, 16'h4400, 4'd1);
    send(16'hC000, 16'h4000, 4'd2);
    wait_results(2);
    check("t2_data0", 32'(res_q[0].data), 32'h4800);
    check("t2_data1", 32'(res_q[1].data), 32'hC000);
    check("t2_tags", {24'd0, res_q[0].tag, res_q[1].tag}, 32'h12);
    check("t2_spacing", 32'(res_q[1].cyc - res_q[0].cyc), 32'd2);
    repeat (2) tick();

    // 3: NaR and zero operands pass flags through
    clear_logs();
    send(16'h8000, 16'h4000, 4'd5);
    send(16'h0000, 16'h4400, 4'd6);
    wait_results(2);
    check("t3_nar_data", 32'(res_q[0].data), 32'h8000);
    check("t3_nar_flags", {30'd0, res_q[0].inf, res_q[0].zero}, 32'h2);
    check("t3_zero_flags", {30'd0, res_q[1].inf, res_q[1].zero}, 32'h1);
    repeat (2) tick();

    // 4: back-pressure: 4 in FIFO + 1 in HOLD, then drain in order
    bus.res_ready = 1'b0;
    clear_logs();
    n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      bit acc;
      bus.op_a     = 16'h4000;
      bus.op_b     = t4_b[n_acc];
      bus.op_tag   = TW'(n_acc);
      bus.op_valid = 1'b1;
      acc = bus.op_ready;
      tick();
      if (acc) n_acc++;
      if (n_acc > 5) n_acc = 5;
    end
    bus.op_valid = 1'b0;
    check("t4_accepts", 32'(acc_q.size()), 32'd5);
    check("t4_op_ready", 32'(bus.op_ready), 32'd0);
    check("t4_count_full", 32'(count), 32'd4);
    bus.res_ready = 1'b1;
    wait_results(5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_data%0d", i), 32'(res_q[i].data), 32'(t4_b[i]));
      check($sformatf("t4_tag%0d", i), 32'(res_q[i].tag), 32'(i));
    end
    repeat (3) tick();

    // 5: flush with one op in HOLD and 3 queued, together with res_ready
    bus.res_ready = 1'b0;
    clear_logs();
    send(16'h4000, 16'h4800, 4'd7);
    send(16'h4000, 16'h4400, 4'd8);
    send(16'h4000, 16'h4400, 4'd9);
    send(16'h4000, 16'h4400, 4'd10);
    repeat (2) tick();
    check("t5_count_pre", 32'(count), 32'd3);
    check("t5_hold", 32'(bus.res_valid), 32'd1);
    s0 = n_start;
    flush         = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_count_post", 32'(count), 32'd0);
    repeat (10) tick();
    check("t5_no_start", 32'(n_start), 32'(s0));
    check("t5_res_count", 32'(res_q.size()), 32'd1);
    check("t5_held_data", {12'd0, res_q[0].tag, res_q[0].data}, {12'd0, 4'd7, 16'h4800});
    check("t5_idle", {30'd0, bus.res_valid, bus.op_ready}, 32'h1);

    // 6a: slow multiplier exercises WAIT
    slow_mode = 1'b1;
    clear_logs();
    send(16'h4000, 16'hC000, 4'd9);
    wait_results(1);
    check("t6a_data", 32'(res_q[0].data), 32'hC000);
    check("t6a_latency", 32'(res_q[0].cyc - acc_q[0]), 32'd6);
    repeat (2) tick();

    // 6b: async reset in the middle of WAIT
    clear_logs();
    send(16'h4400, 16'h4400, 4'd4);
    tick();
    check("t6_issue", {15'd0, bus.mul_start, bus.mul_in1}, {15'd0, 1'b1, 16'h4400});
    tick();
    check("t6_wait", {14'd0, bus.mul_start, bus.res_valid, bus.mul_in2}, {14'd0, 2'b00, 16'h4400});
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_mul_in", {bus.mul_in1, bus.mul_in2}, 32'd0);
    check("t6_rst_flags", {29'd0, bus.mul_start, bus.res_valid, bus.op_ready}, 32'h1);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_res", {12'd0, bus.res_tag, bus.res_data}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    slow_mode = 1'b0;
    tick();
    clear_logs();
    send(16'hC000, 16'hC000, 4'd6);
    wait_results(1);
    check("t6_after_data", {12'd0, res_q[0].tag, res_q[0].data}, {12'd0, 4'd6, 16'h4000});
    check("t6_after_latency", 32'(res_q[0].cyc - acc_q[0]), 32'd3);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
